mouse_ptr_scheduler: RTL

//  Frame-synchronous controller for the mouse pointer. Sits between the PS/2 mouse packet

---
 rtl/mouse_ptr_scheduler_if.sv | 24 ++
 rtl/mouse_ptr_scheduler.sv | 111 +++++++++++
 2 files changed

// File: rtl/mouse_ptr_scheduler_if.sv
// mouse_ptr_scheduler_if: mouse packet inputs, frame pulse and committed pointer outputs
//   master : drives m_done_tick, x, y, btn, frame_start; observes ptr_x, ptr_y, ptr_color,
//            update_tick, overflow
//   slave  : the scheduler side of the same signals
interface mouse_ptr_scheduler_if;
   logic       m_done_tick;
   logic [8:0] x;
   logic [8:0] y;
   logic [2:0] btn;
   logic       frame_start;
   logic [9:0] ptr_x;
   logic [9:0] ptr_y;
   logic [2:0] ptr_color;
   logic       update_tick;
   logic       overflow;
   modport master (
      output m_done_tick, x, y, btn, frame_start,
      input  ptr_x, ptr_y, ptr_color, update_tick, overflow
   );
   modport slave (
      input  m_done_tick, x, y, btn, frame_start,
      output ptr_x, ptr_y, ptr_color, update_tick, overflow
   );
endinterface

// File: rtl/mouse_ptr_scheduler.sv
// mouse_ptr_scheduler: frame-synchronous pointer controller; accumulates PS/2 deltas and clicks, commits once per vblank
//   clk, rst_n        : clock, synchronous active-low reset
//   bus.m_done_tick   : packet strobe; bus.x / bus.y signed 9-bit deltas (y up positive); bus.btn {m,r,l}
//   bus.frame_start   : vblank pulse that starts a commit (IDLE -> SUM -> CLAMP)
//   bus.ptr_x/ptr_y   : committed top-left of the pointer, clamped inside the visible area
//   bus.ptr_color     : committed colour {b,g,r}
//   bus.update_tick   : one-cycle pulse when ptr_* take new values
//   bus.overflow      : sticky, an accumulator saturated since the last commit
module mouse_ptr_scheduler #(
   parameter int H_MAX = 639,
   parameter int V_MAX = 479,
   parameter int SIZE  = 16,
   parameter int ACC_W = 12
) (
   input logic                  clk,
   input logic                  rst_n,
   mouse_ptr_scheduler_if.slave bus
);
   localparam logic signed [ACC_W:0] X_LIM   = (ACC_W+1)'(H_MAX + 1 - SIZE);
   localparam logic signed [ACC_W:0] Y_LIM   = (ACC_W+1)'(V_MAX + 1 - SIZE);
   localparam logic signed [ACC_W:0] ACC_MAX = (ACC_W+1)'(2 ** (ACC_W - 1) - 1);
   localparam logic signed [ACC_W:0] ACC_MIN = (ACC_W+1)'(-(2 ** (ACC_W - 1)));
   localparam logic [9:0]            X_CTR   = 10'((H_MAX + 1 - SIZE) / 2);
   localparam logic [9:0]            Y_CTR   = 10'((V_MAX + 1 - SIZE) / 2);

   typedef enum logic [1:0] {IDLE, SUM, CLAMP} state_t;
   state_t state;

   logic [ACC_W-1:0]      acc_x, acc_y, snap_x, snap_y, nx, ny;
   logic signed [ACC_W:0] raw_x, raw_y, sx, sy;
   logic [2:0]            col_acc, snap_col, ncol, btn_prev, rise;
   logic                  home_req, snap_home, nhome, sat_hit;

   function automatic logic [ACC_W-1:0] sat(input logic signed [ACC_W:0] v);
      return v > ACC_MAX ? ACC_MAX[ACC_W-1:0] : v < ACC_MIN ? ACC_MIN[ACC_W-1:0] : v[ACC_W-1:0];
   endfunction

   function automatic logic [9:0] clamp(input logic signed [ACC_W:0] v, input logic signed [ACC_W:0] lim);
      return v[ACC_W] ? '0 : v > lim ? lim[9:0] : v[9:0];
   endfunction

   // Next live accumulator values; Y is negated because screen rows grow downwards.
   always_comb begin
      rise    = bus.btn & ~btn_prev & {3{bus.m_done_tick}};
      raw_x   = $signed({acc_x[ACC_W-1], acc_x}) + $signed({{(ACC_W-8){bus.x[8]}}, bus.x});
      raw_y   = $signed({acc_y[ACC_W-1], acc_y}) - $signed({{(ACC_W-8){bus.y[8]}}, bus.y});
      nx      = bus.m_done_tick ? sat(raw_x) : acc_x;
      ny      = bus.m_done_tick ? sat(raw_y) : acc_y;
      ncol    = col_acc + {2'b0, rise[1]} - {2'b0, rise[0]};
      nhome   = home_req | rise[2];
      sat_hit = bus.m_done_tick && (raw_x > ACC_MAX || raw_x < ACC_MIN || raw_y > ACC_MAX || raw_y < ACC_MIN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         acc_x           <= '0;
         acc_y           <= '0;
         col_acc         <= '0;
         home_req        <= 1'b0;
         snap_x          <= '0;
         snap_y          <= '0;
         snap_col        <= '0;
         snap_home       <= 1'b0;
         sx              <= '0;
         sy              <= '0;
         btn_prev        <= '0;
         bus.ptr_x       <= X_CTR;
         bus.ptr_y       <= Y_CTR;
         bus.ptr_color   <= '0;
         bus.update_tick <= 1'b0;
         bus.overflow    <= 1'b0;
      end else begin
         acc_x           <= nx;
         acc_y           <= ny;
         col_acc         <= ncol;
         home_req        <= nhome;
         if (bus.m_done_tick) btn_prev <= bus.btn;
         bus.update_tick <= 1'b0;
         // A saturation in the commit cycle belongs to the next frame, so it survives the clear.
         bus.overflow    <= (state != CLAMP && bus.overflow) || sat_hit;
         case (state)
            IDLE: if (bus.frame_start) begin
               // The snapshot takes the next values so a coincident tick lands in this commit.
               snap_x    <= nx;
               snap_y    <= ny;
               snap_col  <= ncol;
               snap_home <= nhome;
               acc_x     <= '0;
               acc_y     <= '0;
               col_acc   <= '0;
               home_req  <= 1'b0;
               state     <= SUM;
            end
            SUM: begin
               sx    <= $signed({{(ACC_W-9){1'b0}}, bus.ptr_x}) + $signed({snap_x[ACC_W-1], snap_x});
               sy    <= $signed({{(ACC_W-9){1'b0}}, bus.ptr_y}) + $signed({snap_y[ACC_W-1], snap_y});
               state <= CLAMP;
            end
            CLAMP: begin
               bus.ptr_x       <= snap_home ? X_CTR : clamp(sx, X_LIM);
               bus.ptr_y       <= snap_home ? Y_CTR : clamp(sy, Y_LIM);
               bus.ptr_color   <= snap_home ? 3'd0 : bus.ptr_color + snap_col;
               bus.update_tick <= 1'b1;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
